// File: rtl/host_drv_pkg.sv
// Shared definitions for the host matrix driver.
//   - Default parameter values for data width, address width and read latency.
//   - Controller state encoding.
package host_drv_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAw    = 32;
    localparam int unsigned DefRdLat = 1;

    typedef enum logic [3:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StRun,
        StWaitFin,
        StRdIssue,
        StRdWait,
        StRdOut,
        StDone
    } drv_state_e;

endpackage

// File: rtl/host_rd_port.sv
// Accelerator read port: issues one read, waits RD_LAT cycles, captures the
// returned word and holds it on the out stream until it is accepted.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   issue_i, addr_i       one-cycle read request from the controller and its address
//   cap_o                 high in the cycle ram_data is captured
//   hs_o                  out_valid && out_ready handshake
//   arvalid, read_addr    read request towards the accelerator
//   ram_data              read data, valid RD_LAT cycles after arvalid
//   out_valid/out_ready/out_data  result stream
// RD_LAT must be at least 1.
module host_rd_port
    import host_drv_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned AW     = DefAw,
    parameter int unsigned RD_LAT = DefRdLat
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_i,
    input  logic [AW-1:0]     addr_i,
    output logic              cap_o,
    output logic              hs_o,
    output logic              arvalid,
    output logic [AW-1:0]     read_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic              waiting_q, waiting_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign arvalid   = issue_i;
    assign read_addr = issue_i ? addr_i : '0;
    // cnt_q counts down the remaining wait cycles; zero marks the data cycle.
    assign cap_o     = waiting_q && (cnt_q == '0);
    assign hs_o      = valid_q && out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        waiting_d = waiting_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        data_d    = data_q;
        if (hs_o) begin
            valid_d = 1'b0;
        end
        if (issue_i) begin
            waiting_d = 1'b1;
            cnt_d     = CntW'(RD_LAT - 1);
        end else if (cap_o) begin
            waiting_d = 1'b0;
            valid_d   = 1'b1;
            data_d    = ram_data;
        end else if (waiting_q) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waiting_q <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            waiting_q <= waiting_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: rtl/host_matrix_driver.sv
// Host-side driver for a matrix accelerator: streams A then B (N*N words each)
// into the accelerator write port, pulses go, waits for finish, then reads back
// the N*N result words one at a time onto the out stream.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   start, matrix_size              job launch and N (sampled on accepted start)
//   in_valid/in_ready/in_data       load stream (A words then B words)
//   A_cho, B_cho, wready_q,
//   write_addr, hello_world_q       accelerator write port
//   go, work, finish                accelerator run control
//   arvalid, read_addr, ram_data    accelerator read port
//   out_valid/out_ready/out_data    result stream
//   busy, done                      status
module host_matrix_driver
    import host_drv_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned AW     = DefAw,
    parameter int unsigned RD_LAT = DefRdLat
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       matrix_size,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              A_cho,
    output logic              B_cho,
    output logic              wready_q,
    output logic [AW-1:0]     write_addr,
    output logic [DATA_W-1:0] hello_world_q,
    output logic              go,
    output logic              work,
    input  logic              finish,
    output logic              arvalid,
    output logic [AW-1:0]     read_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    drv_state_e        state_q, state_d;
    logic [31:0]       total_q, total_d;  // N*N
    logic [31:0]       k_q, k_d;          // words accepted for the current matrix
    logic [31:0]       j_q, j_d;          // current read index
    logic              wr_valid_q, wr_valid_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic load_st, all_in, accept, rd_issue, rd_cap, rd_hs;

    assign load_st  = (state_q == StLoadA) || (state_q == StLoadB);
    assign all_in   = (k_q == total_q);
    assign in_ready = load_st && !all_in;
    assign accept   = in_valid && in_ready;
    assign rd_issue = (state_q == StRdIssue);

    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        k_d        = k_q;
        j_d        = j_q;
        wr_valid_d = accept;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (accept) begin
            wr_addr_d = AW'(k_q);
            wr_data_d = in_data;
            k_d       = k_q + 32'd1;
        end
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    total_d = matrix_size * matrix_size;
                    k_d     = '0;
                    j_d     = '0;
                    state_d = (matrix_size == '0) ? StDone : StLoadA;
                end
            end
            // A load phase ends one cycle after its last write beat, so the
            // select of one matrix never overlaps a write beat of the other.
            StLoadA, StLoadB: begin
                if (all_in && !wr_valid_q) begin
                    k_d     = '0;
                    state_d = (state_q == StLoadA) ? StLoadB : StRun;
                end
            end
            StRun: state_d = StWaitFin;
            StWaitFin: begin
                if (finish) begin
                    j_d     = '0;
                    state_d = StRdIssue;
                end
            end
            StRdIssue: state_d = StRdWait;
            StRdWait: begin
                if (rd_cap) begin
                    state_d = StRdOut;
                end
            end
            StRdOut: begin
                if (rd_hs) begin
                    if (j_q == total_q - 32'd1) begin
                        state_d = StDone;
                    end else begin
                        j_d     = j_q + 32'd1;
                        state_d = StRdIssue;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            total_q    <= '0;
            k_q        <= '0;
            j_q        <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            k_q        <= k_d;
            j_q        <= j_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign A_cho         = (state_q == StLoadA);
    assign B_cho         = (state_q == StLoadB);
    assign wready_q      = wr_valid_q;
    assign write_addr    = wr_addr_q;
    assign hello_world_q = wr_data_q;
    assign go            = (state_q == StRun);
    assign work          = (state_q == StRun) || (state_q == StWaitFin);
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);

    host_rd_port #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_rd_port (
        .clk       (clk),
        .reset     (reset),
        .issue_i   (rd_issue),
        .addr_i    (AW'(j_q)),
        .cap_o     (rd_cap),
        .hs_o      (rd_hs),
        .arvalid   (arvalid),
        .read_addr (read_addr),
        .ram_data  (ram_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_host_matrix_driver.sv
// Bench for host_matrix_driver: table of jobs, scoreboard queues for write
// beats and read results, a RAM model answering reads, and hand sequences for
// matrix_size=0 and reset in the middle of a load.
module tb_host_matrix_driver;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AW     = 32;
    localparam int unsigned RD_LAT = 2;
    localparam logic [DATA_W-1:0] GARBAGE = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [31:0]       matrix_size;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              A_cho, B_cho, wready_q;
    logic [AW-1:0]     write_addr;
    logic [DATA_W-1:0] hello_world_q;
    logic              go, work, finish;
    logic              arvalid;
    logic [AW-1:0]     read_addr;
    logic [DATA_W-1:0] ram_data = GARBAGE;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              busy, done;

    always #5 clk = ~clk;

    host_matrix_driver #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .matrix_size   (matrix_size),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .A_cho         (A_cho),
        .B_cho         (B_cho),
        .wready_q      (wready_q),
        .write_addr    (write_addr),
        .hello_world_q (hello_world_q),
        .go            (go),
        .work          (work),
        .finish        (finish),
        .arvalid       (arvalid),
        .read_addr     (read_addr),
        .ram_data      (ram_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .done          (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM model contents for result C: C[r][c] = 8*((c+1)%4) + r.
    function automatic logic [DATA_W-1:0] c_word(input int n, input int idx);
        int r, c;
        if (n == 0) return '0;
        r = idx / n;
        c = idx % n;
        return DATA_W'(8 * ((c + 1) % 4) + r);
    endfunction

    typedef struct {
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic              mat;   // 0: A, 1: B
    } wr_exp_t;

    typedef struct {
        int n;
        bit gaps;       // random in_valid gaps
        bit slow;       // out_ready high one cycle in three
        int fin_dly;    // cycles from go to finish
        bit idx_data;   // data = (i+1)%4 instead of random
        int exp_words;  // result words expected
    } job_t;

    // Scoreboard state; written only by the monitor process.
    wr_exp_t           wr_q[$];
    logic [DATA_W-1:0] out_q[$];
    int n_hs = 0, n_wr = 0, n_ar = 0, n_go = 0, rd_cnt = 0, cyc = 0;
    int last_wr_cyc = 0, ram_wait = 0, ram_addr = 0;
    logic prev_ov = 1'b0, prev_or = 1'b0;
    logic [DATA_W-1:0] prev_od = '0;
    wr_exp_t e;

    // Job context; written only by the main process.
    int cur_n = 0, hs_base = 0, ar_base = 0;
    bit slow_mode = 1'b0, no_gap_mode = 1'b0;

    int orc = 0;
    always @(posedge clk) begin
        #1;
        orc++;
        out_ready = slow_mode ? (orc % 3 == 0) : 1'b1;
    end

    always @(negedge clk) begin
        int hs, nn;
        cyc++;
        nn = (cur_n == 0) ? 1 : cur_n * cur_n;
        ram_data = GARBAGE;
        if (!reset) begin
            wr_q.delete();
            out_q.delete();
            ram_wait = 0;
            prev_ov  = 1'b0;
        end else begin
            if (ram_wait > 0) begin
                ram_wait--;
                if (ram_wait == 0) ram_data = c_word(cur_n, ram_addr);
            end
            if (wready_q) begin
                n_wr++;
                if (wr_q.size() == 0) begin
                    chk("wr_pending", 64'(wr_q.size()), 1);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", write_addr, e.addr);
                    chk("wr_data", hello_world_q, e.data);
                    chk("wr_cho", {A_cho, B_cho}, e.mat ? 2'b01 : 2'b10);
                    if (no_gap_mode && write_addr != '0) chk("wr_no_gap", cyc - last_wr_cyc, 1);
                end
                last_wr_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                hs = n_hs - hs_base;
                e.addr = AW'(hs % nn);
                e.data = in_data;
                e.mat  = (hs >= nn);
                wr_q.push_back(e);
                n_hs++;
            end
            if (arvalid) begin
                chk("rd_addr", read_addr, 64'(n_ar - ar_base));
                chk("rd_none_pending", {out_valid, ram_wait != 0}, 2'b00);
                out_q.push_back(c_word(cur_n, n_ar - ar_base));
                ram_addr = int'(read_addr);
                ram_wait = RD_LAT;
                n_ar++;
            end
            if (prev_ov && !prev_or) begin
                chk("out_hold_valid", out_valid, 1);
                chk("out_hold_data", out_data, prev_od);
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) chk("out_pending", 64'(out_q.size()), 1);
                else chk("out_data", out_data, out_q.pop_front());
                rd_cnt++;
            end
            if (go) n_go++;
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_od = out_data;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_cho"}, {A_cho, B_cho}, 0);
        chk({tag, "_wready"}, wready_q, 0);
        chk({tag, "_waddr"}, write_addr, 0);
        chk({tag, "_wdata"}, hello_world_q, 0);
        chk({tag, "_go_work"}, {go, work}, 0);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_raddr"}, read_addr, 0);
        chk({tag, "_out"}, {out_valid, out_data}, 0);
        chk({tag, "_busy_done"}, {busy, done}, 0);
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        matrix_size = n;
        @(posedge clk); #1;
        start = 1'b0;
        matrix_size = 32'h0000_FFFF;  // must have been sampled already
    endtask

    // Present one word and wait (bounded) for it to be accepted.
    task automatic send_word(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input job_t j);
        int nn, wr0, ar0, rd0, go0;
        nn  = j.n * j.n;
        wr0 = n_wr; ar0 = n_ar; rd0 = rd_cnt; go0 = n_go;
        cur_n = j.n; hs_base = n_hs; ar_base = n_ar;
        slow_mode = j.slow; no_gap_mode = !j.gaps;
        pulse_start(j.n);
        chk("busy_after_start", busy, 1);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < nn; i++) begin
                if (j.gaps && $urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                send_word(j.idx_data ? DATA_W'((i + 1) % 4) : DATA_W'($urandom));
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (go) break;
        end
        chk("go_seen", go, 1);
        @(negedge clk);
        chk("go_one_cycle", go, 0);
        chk("work_high", work, 1);
        repeat (j.fin_dly - 1) @(negedge clk);
        chk("work_before_finish", work, 1);
        @(posedge clk); #1;
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        @(negedge clk);
        chk("work_after_finish", work, 0);
        for (int k = 0; k < 20000; k++) begin
            if (done) break;
            @(negedge clk);
        end
        chk("done_seen", done, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_not_busy", busy, 0);
        chk("wr_count", n_wr - wr0, 2 * nn);
        chk("ar_count", n_ar - ar0, nn);
        chk("rd_count", rd_cnt - rd0, j.exp_words);
        chk("go_count", n_go - go0, 1);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("out_q_empty", out_q.size(), 0);
    endtask

    job_t jobs[4];

    initial begin
        int w0, g0, a0;
        bit found;
        jobs[0] = '{n: 8, gaps: 0, slow: 0, fin_dly: 100, idx_data: 1, exp_words: 64};
        jobs[1] = '{n: 3, gaps: 1, slow: 1, fin_dly: 5,   idx_data: 0, exp_words: 9};
        jobs[2] = '{n: 1, gaps: 0, slow: 1, fin_dly: 1,   idx_data: 0, exp_words: 1};
        jobs[3] = '{n: 4, gaps: 1, slow: 0, fin_dly: 3,   idx_data: 0, exp_words: 16};

        reset = 1'b0; start = 1'b0; matrix_size = '0;
        in_valid = 1'b0; in_data = '0; finish = 1'b0;
        #1 check_all_zero("reset0");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        for (int t = 0; t < 4; t++) run_job(jobs[t]);

        // matrix_size = 0: done within two cycles and no port activity.
        w0 = n_wr; g0 = n_go; a0 = n_ar;
        cur_n = 0;
        pulse_start(0);
        found = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        chk("n0_done", found, 1);
        repeat (3) @(negedge clk);
        chk("n0_activity", {32'(n_wr - w0), 16'(n_go - g0), 16'(n_ar - a0)}, 0);
        chk("n0_idle", busy, 0);

        // Reset during LOAD_A right after beat 20 is accepted.
        cur_n = 8; hs_base = n_hs; ar_base = n_ar; no_gap_mode = 1'b1; slow_mode = 1'b0;
        pulse_start(8);
        for (int i = 0; i < 20; i++) send_word(DATA_W'(i + 100));
        chk("pre_reset_wready", wready_q, 1);
        #2 reset = 1'b0;
        #1 check_all_zero("mid_reset");
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_resume_busy", busy, 0);
        chk("no_resume_in_ready", in_ready, 0);
        run_job('{n: 2, gaps: 0, slow: 0, fin_dly: 3, idx_data: 0, exp_words: 4});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/host_matrix_driver.md
HOST_MATRIX_DRIVER -- requirements
Module: host_matrix_driver

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the write data, read data and stream data.
REQ-002 SHALL have parameter AW, default 32, meaning the width of write_addr and read_addr.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning the number of cycles from an arvalid beat to a valid ram_data.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports start (input, 1) and matrix_size (input, 32): start launches a job of N = matrix_size, sampled when start is accepted.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_W): the load stream, carrying the N*N words of A followed by the N*N words of B.
REQ-008 SHALL have ports A_cho, B_cho, wready_q (outputs, 1), write_addr (output, AW) and hello_world_q (output, DATA_W): the accelerator write port.
REQ-009 SHALL have ports go and work (outputs, 1) and finish (input, 1): the accelerator run control.
REQ-010 SHALL have ports arvalid (output, 1), read_addr (output, AW) and ram_data (input, DATA_W): the accelerator read port.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, DATA_W): the result stream of N*N words of C.
REQ-012 SHALL have ports busy (output, 1) and done (output, 1).

Function
REQ-013 SHALL implement the states IDLE, LOAD_A, LOAD_B, RUN, WAIT_FIN, RD_ISSUE, RD_WAIT, RD_OUT and DONE.
REQ-014 SHALL in IDLE accept start and capture N; if N==0, go to DONE without any write, go or read; otherwise go to LOAD_A.
REQ-015 SHALL hold in_ready=1 only in LOAD_A and LOAD_B; each in_valid&&in_ready beat drives one write beat on the next cycle.
REQ-016 SHALL drive each write beat as wready_q=1, write_addr=k and hello_world_q=in_data, with k counting 0..N*N-1 per matrix.
REQ-017 SHALL drive wready_q=0 in every cycle without a write beat; input gaps insert idle cycles and never skip an address.
REQ-018 SHALL hold A_cho=1 throughout LOAD_A and B_cho=1 throughout LOAD_B; A_cho and B_cho are never 1 together.
REQ-019 SHALL hold A_cho (B_cho) from one cycle before the first beat of its matrix until one cycle after the last beat.
REQ-020 SHALL, after the last B beat, enter RUN, pulse go for exactly 1 cycle, raise work, and go to WAIT_FIN.
REQ-021 SHALL hold work=1 from RUN until finish is sampled high in WAIT_FIN; finish outside WAIT_FIN is ignored.
REQ-022 SHALL issue reads one at a time: in RD_ISSUE drive a 1-cycle arvalid with read_addr=j (j = 0..N*N-1), with only one read outstanding.
REQ-023 SHALL wait RD_LAT cycles in RD_WAIT, then capture ram_data into out_data and assert out_valid in RD_OUT.
REQ-024 SHALL hold out_data stable while out_valid&&!out_ready; on the handshake go to the next RD_ISSUE, or to DONE after j==N*N-1.
REQ-025 SHALL pulse done for 1 cycle in DONE, then return to IDLE.
REQ-026 SHALL drive busy=1 in every state except IDLE and ignore start while busy.
REQ-027 SHALL compute N*N and the counters at 32-bit width; N*N larger than 2^AW is unsupported, and the address wraps modulo 2^AW.

Reset
REQ-028 SHALL, on reset low, immediately force the state to IDLE and all outputs to 0, including A_cho, B_cho, wready_q, go, work, arvalid, out_valid, busy and done.
REQ-029 SHALL, after reset is asserted mid-job, wait for a new start; a partial job is never resumed.

Structure
REQ-030 SHALL put the state enum and the default parameter values in a shared package, host_drv_pkg.
REQ-031 SHALL have one sub-module, host_rd_port, which owns the arvalid/RD_LAT delay/capture/out handshake.

Verification
REQ-032 SHALL cover: N=8, A words (i+1)%4 then B words (i+1)%4 with in_valid held 1 -> write_addr 0..63 with A_cho, then 0..63 with B_cho, and no gaps.
REQ-033 SHALL cover: a run -> go high for exactly 1 cycle; finish model asserted 100 cycles later -> work drops, then reads 0..63 in order.
REQ-034 SHALL cover: a read-back against a RAM model holding C (row0 = 8,16,24,0,8,16,24,0) -> out_data sequence matches, 64 words, followed by one done pulse.
REQ-035 SHALL cover: out_ready toggled 1-of-3 cycles and in_valid random gaps -> no data lost or duplicated, and arvalid never issued with a word pending.
REQ-036 SHALL cover: matrix_size=0 -> done pulse within 2 cycles, and no wready_q, go or arvalid activity.
REQ-037 SHALL cover: reset low during LOAD_A at beat 20 -> all outputs 0 asynchronously; a new job then restarts at write_addr 0.
